// File: rtl/mac_unit_vert_accum.sv
// Vertical bit-column MAC: for one latched activation vector, consumes W_BITS
// weight bit-columns MSB first and accumulates the shifted column partial sums.
//   state | meaning
//   IDLE  | waiting for start; result holds the last value
//   RUN   | one column consumed per accepted col_valid beat
//   DONE  | result valid, waiting for out_ready
module mac_unit_vert_accum #(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 8,
  parameter int NUM_LANE      = VEC_LENGTH / 2,
  parameter int WINDOW        = VEC_LENGTH / 2 + 1,
  parameter int SEL_WIDTH     = $clog2(WINDOW),
  parameter int W_BITS        = 8,
  parameter int SUM_ACT_WIDTH = $clog2(VEC_LENGTH) + DATA_WIDTH,
  parameter int ACC_WIDTH     = DATA_WIDTH + 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start_valid,
  output logic                                    start_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   act_in,
  input  logic signed [SUM_ACT_WIDTH-1:0]         sum_act,
  input  logic                                    load_accum,
  input  logic signed [ACC_WIDTH-1:0]             accum_prev,
  input  logic                                    col_valid,
  output logic                                    col_ready,
  input  logic [NUM_LANE-1:0][SEL_WIDTH-1:0]      act_sel,
  input  logic [NUM_LANE-1:0]                     act_val,
  input  logic                                    is_skip_zero,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic signed [ACC_WIDTH-1:0]             result
);

  localparam int CNT_W = (W_BITS > 1) ? $clog2(W_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MSB = CNT_W'(W_BITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state, state_next;
  logic signed [DATA_WIDTH-1:0]    act_q [VEC_LENGTH];
  logic signed [SUM_ACT_WIDTH-1:0] sum_act_q;
  logic signed [ACC_WIDTH-1:0]     acc;
  logic [CNT_W-1:0]                col_cnt;

  logic signed [DATA_WIDTH-1:0]    lane_op [NUM_LANE];
  logic signed [SUM_ACT_WIDTH-1:0] sel_sum;
  logic signed [SUM_ACT_WIDTH-1:0] psum_raw;
  logic signed [SUM_ACT_WIDTH-1:0] psum;
  logic signed [ACC_WIDTH-1:0]     acc_add;

  // Windows past the vector end or selects past WINDOW never match, giving 0.
  always_comb begin
    for (int j = 0; j < NUM_LANE; j++) begin
      lane_op[j] = '0;
      for (int k = 0; k < WINDOW && (j + k) < VEC_LENGTH; k++) begin
        if (act_val[j] && act_sel[j] == SEL_WIDTH'(k)) lane_op[j] = act_q[j+k];
      end
    end
  end

  always_comb begin
    sel_sum = '0;
    for (int j = 0; j < NUM_LANE; j++) begin
      sel_sum = sel_sum + {{(SUM_ACT_WIDTH-DATA_WIDTH){lane_op[j][DATA_WIDTH-1]}}, lane_op[j]};
    end
  end

  assign psum_raw = is_skip_zero ? sel_sum : (sum_act_q - sel_sum);
  assign psum     = (col_cnt == CNT_MSB) ? -psum_raw : psum_raw;
  assign acc_add  = {{(ACC_WIDTH-SUM_ACT_WIDTH){psum[SUM_ACT_WIDTH-1]}}, psum} << col_cnt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_valid) state_next = RUN;
      RUN:     if (col_valid && col_cnt == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      col_cnt   <= '0;
      sum_act_q <= '0;
      for (int i = 0; i < VEC_LENGTH; i++) act_q[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          for (int i = 0; i < VEC_LENGTH; i++) act_q[i] <= act_in[i];
          sum_act_q <= sum_act;
          acc       <= load_accum ? accum_prev : '0;
          col_cnt   <= CNT_MSB;
        end
        RUN: if (col_valid) begin
          acc <= acc + acc_add;
          if (col_cnt != '0) col_cnt <= col_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign col_ready   = (state == RUN);
  assign out_valid   = (state == DONE);
  assign result      = acc;

endmodule

// File: tb/tb_mac_unit_vert_accum.sv
// Bench for mac_unit_vert_accum: scripted column schedules plus random beats,
// expected results queued at start and compared when out_valid rises.
module tb_mac_unit_vert_accum;
  localparam int DW = 8, VL = 8, NL = 4, WIN = 5, SW = 3, WB = 8, SAW = 11, AW = 24;

  logic clk = 1'b0;
  logic reset;
  logic start_valid, start_ready;
  logic [VL-1:0][DW-1:0] act_in;
  logic signed [SAW-1:0] sum_act;
  logic load_accum;
  logic signed [AW-1:0] accum_prev;
  logic col_valid, col_ready;
  logic [NL-1:0][SW-1:0] act_sel;
  logic [NL-1:0] act_val;
  logic is_skip_zero;
  logic out_valid, out_ready;
  logic signed [AW-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  logic signed [AW-1:0] exp_q[$];
  logic signed [DW-1:0] a_m [VL];
  int sum_m;

  always #5 clk = ~clk;

  mac_unit_vert_accum dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .act_in(act_in), .sum_act(sum_act),
    .load_accum(load_accum), .accum_prev(accum_prev),
    .col_valid(col_valid), .col_ready(col_ready),
    .act_sel(act_sel), .act_val(act_val), .is_skip_zero(is_skip_zero),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_valid = 0; col_valid = 0; out_ready = 0; load_accum = 0;
    accum_prev = '0; act_sel = '0; act_val = '0; is_skip_zero = 0;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < VL; i++) a_m[i] = DW'(i + 1);
    sum_m = 36;
  endtask

  task automatic start_op(input logic load, input logic signed [AW-1:0] prev);
    for (int i = 0; i < VL; i++) act_in[i] = a_m[i];
    sum_act = SAW'(sum_m);
    load_accum = load;
    accum_prev = prev;
    start_valid = 1;
    tick();
    start_valid = 0;
    load_accum = ~load;
    accum_prev = AW'($urandom);
    for (int i = 0; i < VL; i++) act_in[i] = DW'($urandom);
    sum_act = SAW'($urandom);
  endtask

  task automatic beat(input logic [NL-1:0][SW-1:0] sel, input logic [NL-1:0] val, input logic skip);
    col_valid = 1; act_sel = sel; act_val = val; is_skip_zero = skip;
    tick();
    col_valid = 0;
    for (int j = 0; j < NL; j++) act_sel[j] = SW'($urandom);
    act_val = NL'($urandom);
    is_skip_zero = 1'($urandom);
  endtask

  function automatic logic signed [SAW-1:0] model_psum(input logic [NL-1:0][SW-1:0] sel,
      input logic [NL-1:0] val, input logic skip, input int c);
    int s;
    logic signed [SAW-1:0] p;
    s = 0;
    for (int j = 0; j < NL; j++)
      if (val[j] && int'(sel[j]) < WIN && j + int'(sel[j]) < VL) s += a_m[j + int'(sel[j])];
    p = skip ? SAW'(s) : SAW'(sum_m - s);
    if (c == WB - 1) p = -p;
    return p;
  endfunction

  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      start_valid = 1'($urandom); col_valid = 1'($urandom); out_ready = 1'($urandom);
      load_accum = 1'($urandom); accum_prev = AW'($urandom);
      for (int k = 0; k < VL; k++) act_in[k] = DW'($urandom);
      act_sel = (NL*SW)'($urandom); act_val = NL'($urandom); is_skip_zero = 1'($urandom);
      tick();
    end
    n_cmp++;
    if (start_ready !== 1'b1 || col_ready !== 1'b0 || out_valid !== 1'b0)
      begin n_bad++; $display("FAIL reset_flags: got sr=%b cr=%b ov=%b want 1 0 0", start_ready, col_ready, out_valid); end
    n_cmp++;
    if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %0d want 0", result); end
    reset = 0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      col_valid = 1'($urandom); out_ready = 1'($urandom);
      tick();
      n_cmp++;
      if (start_ready !== 1'b1 || col_ready !== 1'b0 || out_valid !== 1'b0)
        begin n_bad++; $display("FAIL reset_idle%0d: got sr=%b cr=%b ov=%b want 1 0 0", i, start_ready, col_ready, out_valid); end
    end
    idle_inputs();
  endtask

  task automatic test_weights_one();
    logic signed [AW-1:0] e;
    set_ramp();
    exp_q.push_back(AW'(36));
    start_op(0, '0);
    n_cmp++;
    if (col_ready !== 1'b1 || start_ready !== 1'b0)
      begin n_bad++; $display("FAIL w1_run: got cr=%b sr=%b want 1 0", col_ready, start_ready); end
    for (int c = WB - 1; c >= 1; c--) beat('0, '0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL w1_early: out_valid=%b after 7 beats want 0", out_valid); end
    beat('0, '0, 1'b0);
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || result !== e)
      begin n_bad++; $display("FAIL w1_result: got ov=%b res=%0d want 1 %0d", out_valid, result, e); end
    out_ready = 1;
    tick();
    out_ready = 0;
    n_cmp++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_bad++; $display("FAIL w1_accept: got sr=%b ov=%b want 1 0", start_ready, out_valid); end
  endtask

  task automatic test_weights_ff();
    logic signed [AW-1:0] e;
    set_ramp();
    exp_q.push_back(-AW'(36));
    start_op(0, '0);
    for (int c = WB - 1; c >= 0; c--) beat('0, '0, 1'b0);
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || result !== e)
      begin n_bad++; $display("FAIL wff_result: got ov=%b res=%h want 1 %h", out_valid, result, e); end
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_sparse_seed();
    logic signed [AW-1:0] e;
    logic [NL-1:0][SW-1:0] s;
    set_ramp();
    exp_q.push_back(AW'(109));
    start_op(1, AW'(100));
    for (int c = WB - 1; c >= 1; c--) beat('0, '0, 1'b1);
    s = '0; s[0] = SW'(2); s[1] = SW'(4);
    beat(s, 4'b0011, 1'b1);
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || result !== e)
      begin n_bad++; $display("FAIL sparse_result: got ov=%b res=%0d want 1 %0d", out_valid, result, e); end
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_bubbles_backpressure();
    logic signed [AW-1:0] e;
    set_ramp();
    exp_q.push_back(AW'(36));
    start_op(0, '0);
    for (int c = WB - 1; c >= 0; c--) begin
      beat('0, '0, (c != 0));
      if (c == 4) begin
        tick(); tick();
        n_cmp++;
        if (col_ready !== 1'b1 || out_valid !== 1'b0)
          begin n_bad++; $display("FAIL bubble_hold: got cr=%b ov=%b want 1 0", col_ready, out_valid); end
      end else if (c != 0) tick();
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || result !== e)
      begin n_bad++; $display("FAIL bubble_result: got ov=%b res=%0d want 1 %0d", out_valid, result, e); end
    start_valid = 1; col_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (result !== e || out_valid !== 1'b1 || start_ready !== 1'b0 || col_ready !== 1'b0)
        begin n_bad++; $display("FAIL bp_hold%0d: got res=%0d ov=%b sr=%b cr=%b want %0d 1 0 0", i, result, out_valid, start_ready, col_ready, e); end
    end
    start_valid = 0; col_valid = 0;
    out_ready = 1; tick(); out_ready = 0;
    n_cmp++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0 || result !== e)
      begin n_bad++; $display("FAIL bp_accept: got sr=%b ov=%b res=%0d want 1 0 %0d", start_ready, out_valid, result, e); end
  endtask

  task automatic test_reset_mid_op();
    set_ramp();
    exp_q.push_back(-AW'(36));
    start_op(0, '0);
    for (int i = 0; i < 3; i++) beat('0, '0, 1'b0);
    reset = 1; tick(); reset = 0;
    exp_q.delete();
    n_cmp++;
    if (start_ready !== 1'b1 || col_ready !== 1'b0 || out_valid !== 1'b0 || result !== '0)
      begin n_bad++; $display("FAIL midreset: got sr=%b cr=%b ov=%b res=%0d want 1 0 0 0", start_ready, col_ready, out_valid, result); end
    test_weights_one();
  endtask

  task automatic test_back_to_back();
    logic signed [AW-1:0] e, m;
    logic [NL-1:0][SW-1:0] sel_t [WB];
    logic [NL-1:0] val_t [WB];
    logic skip_t [WB];
    logic ld;
    logic signed [AW-1:0] prev;
    for (int n = 0; n < 6; n++) begin
      sum_m = 0;
      for (int i = 0; i < VL; i++) begin a_m[i] = DW'($urandom); sum_m += a_m[i]; end
      ld = 1'($urandom); prev = AW'($urandom);
      m = ld ? prev : '0;
      for (int c = WB - 1; c >= 0; c--) begin
        for (int j = 0; j < NL; j++) sel_t[c][j] = SW'($urandom_range(0, 7));
        val_t[c] = NL'($urandom); skip_t[c] = 1'($urandom);
        m = m + (AW'(model_psum(sel_t[c], val_t[c], skip_t[c], c)) <<< c);
      end
      exp_q.push_back(m);
      start_op(ld, prev);
      for (int c = WB - 1; c >= 0; c--) beat(sel_t[c], val_t[c], skip_t[c]);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || result !== e)
        begin n_bad++; $display("FAIL rand%0d: got ov=%b res=%h want 1 %h", n, out_valid, result, e); end
      out_ready = 1; tick(); out_ready = 0;
    end
  endtask

  initial begin
    reset = 1;
    act_in = '0; sum_act = '0;
    idle_inputs();
    test_reset();
    test_weights_one();
    test_weights_ff();
    test_sparse_seed();
    test_bubbles_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mac_unit_vert_accum.md
Name: mac_unit_vert_accum

Overview:
Parametrised successor of the vertical bit-column MAC. For one activation vector it processes all W_BITS weight bit-columns, MSB first. Each column beat selects a sparse subset of activations through per-lane windowed muxes, forms the column partial sum, and accumulates it, shifted, into an internal accumulator. A start/column/result valid-ready protocol sequences the work, so the block sits between the column-schedule feeder and the output-channel reduction tree.

Parameters:
DATA_WIDTH, 8, activation width (signed)
VEC_LENGTH, 8, activations per vector; even, >=4
NUM_LANE, VEC_LENGTH/2, selectable lanes per column
WINDOW, VEC_LENGTH/2+1, mux window; lane j sees act[j .. j+WINDOW-1]
SEL_WIDTH, $clog2(WINDOW), per-lane select width
W_BITS, 8, weight bit-columns per vector (2..16)
SUM_ACT_WIDTH, $clog2(VEC_LENGTH)+DATA_WIDTH, width of sum_act and column psum
ACC_WIDTH, DATA_WIDTH+16, accumulator and result width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start_valid  in  1  new vector op offered
start_ready  out  1  block is IDLE and accepts a start
act_in  in  DATA_WIDTH x VEC_LENGTH  signed activations, latched on start
sum_act  in  SUM_ACT_WIDTH  signed sum of act_in, latched on start
load_accum  in  1  at start: 1 = init acc from accum_prev, 0 = init to 0
accum_prev  in  ACC_WIDTH  signed accumulator seed
col_valid  in  1  column beat offered
col_ready  out  1  block is in RUN
act_sel  in  SEL_WIDTH x NUM_LANE  per-lane window offset
act_val  in  NUM_LANE  per-lane valid
is_skip_zero  in  1  1: selected lanes are the 1-bits; 0: selected lanes are the 0-bits
out_valid  out  1  result holds the final value
out_ready  in  1  consumer accepts result
result  out  ACC_WIDTH  signed dot-product result

Behaviour:
- Only clk is used. Reset is synchronous, active-high, and wins over everything.
- Reset values: state=IDLE, acc=0, col_cnt=0, latched act and sum_act=0, start_ready=1, col_ready=0, out_valid=0, result=0.
- FSM states are IDLE, RUN and DONE. Outputs decode from state only: start_ready=(IDLE), col_ready=(RUN), out_valid=(DONE). No combinational path from inputs to ready or valid.
- IDLE, when start_valid=1: latch act_in and sum_act; acc <= load_accum ? accum_prev : 0; col_cnt <= W_BITS-1; go to RUN. If start_valid=0, stay.
- RUN, on each col_valid=1 beat, one column is consumed per cycle:
  - Lane j operand = act_val[j] ? act[j+act_sel[j]] : 0. If act_sel[j] >= WINDOW or j+act_sel[j] >= VEC_LENGTH, the operand is 0.
  - sel_sum = signed sum of the NUM_LANE operands in SUM_ACT_WIDTH.
  - psum = is_skip_zero ? sel_sum : sum_act - sel_sum.
  - If col_cnt == W_BITS-1 (MSB column), psum is negated (two's complement).
  - acc <= acc + (sign-extended psum <<< col_cnt), modulo 2^ACC_WIDTH with no saturation.
  - If col_cnt==0, go to DONE; otherwise decrement col_cnt.
  - If col_valid=0, hold state, col_cnt and acc (a bubble).
- DONE: result is driven from acc and held stable while out_valid=1 and out_ready=0. On out_ready=1, go to IDLE and leave result holding its last value.
- Latency: result is valid the cycle after the W_BITS-th column beat. Best case for one op is 1+W_BITS+1 cycles, IDLE to IDLE.
- start_valid is ignored outside IDLE; col_valid is ignored outside RUN.
- Reset during RUN or DONE discards the op: all state returns to reset values on the next edge.
- The column-beat inputs are sampled only on an accepted beat. The latched act and sum_act are immune to act_in changes after start.

Test Plan:
1. Reset with all inputs toggling -> start_ready=1, col_ready=0, out_valid=0, result=0. The next 3 cycles stay idle.
2. act=[1..8] (act[0]=1), sum_act=36, all weights 0x01. Columns 7..1: skip_zero=1, all val=0. Column 0: skip_zero=0, val=0 -> out_valid exactly 1 cycle after the 8th beat, result=36.
3. Same act, all weights 0xFF. Every column: skip_zero=0, val=0 -> -36·128 + 36·127 = result -36 (0xFFFFDC).
4. Same act; only act[2] and act[5] have weight bit0 set. Column 0: skip_zero=1, lane0 sel=2, lane1 sel=4, others val=0. Other columns give 0. Also start with load_accum=1, accum_prev=100 -> result = 100+3+6 = 109.
5. Test 2 with col_valid=0 bubbles between beats, and out_ready=0 for 3 cycles in DONE -> result unchanged (36), out_valid held, start_ready=0, col_ready=0. Accept on out_ready; start_ready=1 the next cycle.
6. Assert reset after 3 column beats of test 3 -> next cycle IDLE, acc=0, out_valid=0. A new test-2 op then yields 36.
